// File: rtl/fifo_word_serializer_if.sv
// FIFO read port plus byte-stream handshake for the word serializer.
// master = serializer side, slave = FIFO/link side.
interface fifo_word_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_en;
    logic                  fifo_rd;
    logic [7:0]            byte_out;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  byte_last;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  byte_ready,
        output fifo_en,
        output fifo_rd,
        output byte_out,
        output byte_valid,
        output byte_last
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output byte_ready,
        input  fifo_en,
        input  fifo_rd,
        input  byte_out,
        input  byte_valid,
        input  byte_last
    );
endinterface

// File: rtl/fifo_word_serializer.sv
// Drains FIFO words one at a time and streams them out as bytes.
// Counts words whose final byte was accepted downstream.
module fifo_word_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_word_serializer_if.master bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] word_count
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        SEND
    } state_t;

    state_t                state;
    logic [LW-1:0]         lane;
    logic [LW-1:0]         lane_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  fetch;

    assign lane_nxt = lane + 1'b1;
    assign fetch    = enable && !bus.fifo_empty;

    function automatic logic [7:0] pick(
        input logic [DATA_WIDTH-1:0] d,
        input logic [LW-1:0]         idx
    );
        if (MSB_FIRST)
            return d[DATA_WIDTH-1-8*int'(idx) -: 8];
        else
            return d[8*int'(idx) +: 8];
    endfunction

    // fifo_empty is only looked at when a fetch decision is made,
    // so at most one read is ever outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            lane           <= '0;
            shreg          <= '0;
            busy           <= 1'b0;
            word_count     <= '0;
            bus.fifo_en    <= 1'b0;
            bus.fifo_rd    <= 1'b0;
            bus.byte_out   <= 8'h00;
            bus.byte_valid <= 1'b0;
            bus.byte_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetch) begin
                        state       <= REQ;
                        bus.fifo_en <= 1'b1;
                        bus.fifo_rd <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                REQ: begin
                    state       <= WAIT;
                    bus.fifo_en <= 1'b0;
                    bus.fifo_rd <= 1'b0;
                end
                WAIT: begin
                    state          <= SEND;
                    shreg          <= bus.fifo_data;
                    lane           <= '0;
                    bus.byte_out   <= pick(bus.fifo_data, '0);
                    bus.byte_valid <= 1'b1;
                    bus.byte_last  <= (LANES == 1);
                end
                SEND: begin
                    if (bus.byte_ready) begin
                        if (lane == LAST) begin
                            word_count     <= word_count + 1'b1;
                            bus.byte_valid <= 1'b0;
                            bus.byte_last  <= 1'b0;
                            if (fetch) begin
                                state       <= REQ;
                                bus.fifo_en <= 1'b1;
                                bus.fifo_rd <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            lane          <= lane_nxt;
                            bus.byte_out  <= pick(shreg, lane_nxt);
                            bus.byte_last <= (lane_nxt == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: MSB-first instance plus an LSB-first instance
// with a 2-bit word counter for wrap coverage.
module tb_fifo_word_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic busy_a, busy_b;
    logic [15:0] wc_a;
    logic [1:0]  wc_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    fifo_word_serializer_if #(.DATA_WIDTH(32)) ifa ();
    fifo_word_serializer_if #(.DATA_WIDTH(32)) ifb ();

    fifo_word_serializer #(
        .DATA_WIDTH(32), .MSB_FIRST(1'b1), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .bus(ifa),
        .busy(busy_a), .word_count(wc_a)
    );

    fifo_word_serializer #(
        .DATA_WIDTH(32), .MSB_FIRST(1'b0), .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .bus(ifb),
        .busy(busy_b), .word_count(wc_b)
    );

    logic [31:0] mem_a [0:31];
    logic [31:0] mem_b [0:31];
    int rp_a = 0, wp_a = 0, rp_b = 0, wp_b = 0;
    int rdn_a = 0, rdn_b = 0, under_a = 0, enmis_a = 0;
    logic [7:0] by_a [$];
    logic [7:0] by_b [$];
    bit la_a [$];
    bit la_b [$];
    int st_a [$];
    int rds_a [$];

    assign ifa.fifo_empty = (rp_a == wp_a);
    assign ifb.fifo_empty = (rp_b == wp_b);

    // FIFO models with registered data_out, plus byte monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifa.fifo_rd != ifa.fifo_en) enmis_a <= enmis_a + 1;
        if (ifa.fifo_rd) begin
            if (rp_a == wp_a) under_a <= under_a + 1;
            ifa.fifo_data <= mem_a[rp_a[4:0]];
            rp_a <= rp_a + 1;
            rdn_a <= rdn_a + 1;
            rds_a.push_back(cyc);
        end
        if (ifb.fifo_rd) begin
            ifb.fifo_data <= mem_b[rp_b[4:0]];
            rp_b <= rp_b + 1;
            rdn_b <= rdn_b + 1;
        end
        if (ifa.byte_valid && ifa.byte_ready) begin
            by_a.push_back(ifa.byte_out);
            la_a.push_back(ifa.byte_last);
            st_a.push_back(cyc);
        end
        if (ifb.byte_valid && ifb.byte_ready) begin
            by_b.push_back(ifb.byte_out);
            la_b.push_back(ifb.byte_last);
        end
    end

    task automatic push_a(input logic [31:0] w);
        mem_a[wp_a[4:0]] = w;
        wp_a = wp_a + 1;
    endtask

    task automatic push_b(input logic [31:0] w);
        mem_b[wp_b[4:0]] = w;
        wp_b = wp_b + 1;
    endtask

    task automatic wait_a(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (by_a.size() >= n && !busy_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_b(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (by_b.size() >= n && !busy_b) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] flags;
        int r0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        flags = {ifa.fifo_rd, ifa.fifo_en, ifa.byte_valid,
                 ifa.byte_last, busy_a};
        checks++;
        if (flags !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", flags);
        end
        checks++;
        if (ifa.byte_out !== 8'h00 || wc_a !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 00/0000",
                     ifa.byte_out, wc_a);
        end
        @(negedge clk);
        rst = 1'b1;
        en_a = 1'b1;
        r0 = rdn_a;
        repeat (20) @(negedge clk);
        checks++;
        if (rdn_a - r0 != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL empty_idle got rd=%0d busy=%b want 0/0",
                     rdn_a - r0, busy_a);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [4];
        int base, r0, rb;
        bit ok;
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        base = by_a.size();
        r0 = rdn_a;
        rb = rds_a.size();
        push_a(32'hA1B2C3D4);
        wait_a(base + 4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout got 0 want 1");
        end
        checks++;
        if (rdn_a - r0 != 1) begin
            errors++;
            $display("FAIL single_rd got %0d want 1", rdn_a - r0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (by_a.size() <= base + i) begin
                errors++;
                $display("FAIL single_byte%0d got none want %h",
                         i, exp[i]);
            end else if (by_a[base+i] !== exp[i] ||
                         la_a[base+i] != (i == 3) ||
                         st_a[base+i] != st_a[base] + i) begin
                errors++;
                $display("FAIL single_byte%0d got %h/%0d want %h/%0d",
                         i, by_a[base+i], la_a[base+i], exp[i], i == 3);
            end
        end
        checks++;
        if (st_a.size() <= base || rds_a.size() <= rb ||
            st_a[base] - rds_a[rb] != 2) begin
            errors++;
            $display("FAIL single_latency want 2");
        end
        checks++;
        if (wc_a !== 16'd1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single_count got %0d/%b want 1/0",
                     wc_a, busy_a);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4];
        int base;
        bit ok, found;
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        base = by_a.size();
        found = 1'b0;
        push_a(32'hA1B2C3D4);
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (ifa.byte_valid && ifa.byte_out == 8'hB2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_find got 0 want 1");
        end
        ifa.byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ifa.byte_out !== 8'hB2 || ifa.byte_valid !== 1'b1 ||
                ifa.byte_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got %h/%b want b2/1",
                         i, ifa.byte_out, ifa.byte_valid);
            end
        end
        ifa.byte_ready = 1'b1;
        wait_a(base + 4, ok);
        checks++;
        if (!ok || by_a.size() != base + 4) begin
            errors++;
            $display("FAIL bp_count got %0d want %0d",
                     by_a.size(), base + 4);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (by_a.size() <= base + i || by_a[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_byte%0d want %h", i, exp[i]);
            end
        end
        checks++;
        if (wc_a !== 16'd2) begin
            errors++;
            $display("FAIL bp_wc got %0d want 2", wc_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8];
        int base, r0, rb;
        bit ok;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88};
        base = by_a.size();
        r0 = rdn_a;
        rb = rds_a.size();
        push_a(32'h11223344);
        push_a(32'h55667788);
        wait_a(base + 8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout got 0 want 1");
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (by_a.size() <= base + i || by_a[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d want %h", i, exp[i]);
            end
        end
        checks++;
        if (rdn_a - r0 != 2 || rds_a.size() < rb + 2 ||
            rds_a[rb+1] - rds_a[rb] != 6) begin
            errors++;
            $display("FAIL b2b_rd got %0d reads want 2 spaced 6",
                     rdn_a - r0);
        end
        checks++;
        if (by_a.size() >= base + 8 &&
            st_a[base+4] - st_a[base+3] != 3) begin
            errors++;
            $display("FAIL b2b_gap got %0d want 3",
                     st_a[base+4] - st_a[base+3]);
        end
        checks++;
        if (wc_a !== 16'd4 || under_a != 0 || enmis_a != 0) begin
            errors++;
            $display("FAIL b2b_misc got wc=%0d und=%0d mis=%0d want 4/0/0",
                     wc_a, under_a, enmis_a);
        end
    endtask

    task automatic test_mid_word();
        int base, r0;
        bit ok, found;
        base = by_a.size();
        r0 = rdn_a;
        push_a(32'h01020304);
        push_a(32'h05060708);
        for (int i = 0; i < 30 && by_a.size() < base + 1; i++)
            @(negedge clk);
        en_a = 1'b0;
        wait_a(base + 4, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || by_a.size() != base + 4 ||
            by_a[base+3] !== 8'h04) begin
            errors++;
            $display("FAIL en_drop_bytes got %0d want %0d ending 04",
                     by_a.size(), base + 4);
        end
        checks++;
        if (rdn_a - r0 != 1 || busy_a !== 1'b0 ||
            ifa.fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_rd got %0d busy=%b want 1/0",
                     rdn_a - r0, busy_a);
        end
        en_a = 1'b1;
        wait_a(base + 8, ok);
        checks++;
        if (!ok || by_a[base+7] !== 8'h08 || wc_a !== 16'd6) begin
            errors++;
            $display("FAIL en_resume got wc=%0d want 6", wc_a);
        end
        base = by_a.size();
        r0 = rdn_a;
        found = 1'b0;
        push_a(32'h0A0B0C0D);
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (ifa.byte_valid && ifa.byte_out == 8'h0C) found = 1'b1;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (!found || wc_a !== 16'd0 || busy_a !== 1'b0 ||
            ifa.byte_valid !== 1'b0 || ifa.byte_out !== 8'h00 ||
            ifa.byte_last !== 1'b0 || ifa.fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got wc=%0d busy=%b v=%b want 0/0/0",
                     wc_a, busy_a, ifa.byte_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rdn_a - r0 != 1 || busy_a !== 1'b0 ||
            by_a.size() != base + 2) begin
            errors++;
            $display("FAIL rst_discard got rd=%0d bytes=%0d want 1/2",
                     rdn_a - r0, by_a.size() - base);
        end
    endtask

    task automatic test_lsb_wrap();
        logic [7:0] exp [4];
        int base;
        bit ok;
        exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        base = by_b.size();
        en_b = 1'b1;
        push_b(32'hA1B2C3D4);
        wait_b(base + 4, ok);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!ok || by_b.size() <= base + i ||
                by_b[base+i] !== exp[i] || la_b[base+i] != (i == 3)) begin
                errors++;
                $display("FAIL lsb_byte%0d want %h", i, exp[i]);
            end
        end
        checks++;
        if (wc_b !== 2'd1) begin
            errors++;
            $display("FAIL lsb_wc1 got %0d want 1", wc_b);
        end
        push_b(32'h00000001);
        push_b(32'h00000002);
        wait_b(base + 12, ok);
        checks++;
        if (!ok || wc_b !== 2'd3) begin
            errors++;
            $display("FAIL wrap_pre got %0d want 3", wc_b);
        end
        push_b(32'h00000003);
        wait_b(base + 16, ok);
        checks++;
        if (!ok || wc_b !== 2'd0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL wrap got %0d want 0", wc_b);
        end
    endtask

    initial begin
        ifa.byte_ready = 1'b1;
        ifb.byte_ready = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_mid_word();
        test_lsb_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Read-side consumer for the 32-bit FIFO buffer. It drains one word at a time through the FIFO's en/rd/empty interface and captures the registered data_out one cycle after the read. It then emits the word as a stream of bytes over a valid/ready handshake toward the byte-wide link stage. It also keeps a running count of fully transmitted words.

Parameters:
DATA_WIDTH, 32, FIFO word width; must be a multiple of 8
MSB_FIRST, 1, 1 = bits [DATA_WIDTH-1 -: 8] sent first; 0 = bits [7:0] sent first
CNT_WIDTH, 16, width of word_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  permission to start fetching new words
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out, valid from the cycle after fifo_rd
fifo_en  output  1  FIFO enable; high only together with fifo_rd
fifo_rd  output  1  FIFO read strobe, exactly one cycle per word
byte_out  output  8  current byte
byte_valid  output  1  byte_out holds a valid byte
byte_ready  input  1  downstream accepts the byte on the same edge as byte_valid
byte_last  output  1  high with the final byte of each word
busy  output  1  high in any state other than IDLE
word_count  output  CNT_WIDTH  number of words fully accepted downstream

Behaviour:
- All outputs are registered. rst low clears immediately, regardless of clk:
  - state = IDLE
  - fifo_en = fifo_rd = 0
  - byte_out = 0, byte_valid = 0, byte_last = 0
  - busy = 0, word_count = 0, lane index = 0, shift register = 0
- Reset mid-word: the partially sent word is discarded. It is not re-read.
- LANES = DATA_WIDTH/8 (4 at default).
- States: IDLE, REQ, WAIT, SEND.
- IDLE:
  - At a clk edge with enable=1 and fifo_empty=0: go to REQ, with fifo_en=fifo_rd=1 during REQ.
  - Otherwise stay in IDLE with all strobes low.
- REQ: lasts one cycle.
  - fifo_rd/fifo_en drop at the end of REQ.
  - Next state is WAIT.
- WAIT: lasts one cycle.
  - fifo_data is valid. At the closing edge, capture fifo_data into the shift register and set lane=0.
  - Next state is SEND, with byte_valid=1 and byte_out = first lane per MSB_FIRST.
- SEND:
  - While byte_valid=1 and byte_ready=0: byte_out, byte_valid and byte_last hold stable.
  - At an edge with byte_ready=1 and lane < LANES-1: lane increments and the next byte is presented in the following cycle. There are no bubbles between bytes.
  - byte_last=1 exactly while lane = LANES-1.
  - At an edge with byte_ready=1 on the last lane:
    - word_count increments, wrapping from all-ones to 0.
    - byte_valid drops.
    - If enable=1 and fifo_empty=0 at that edge, go to REQ. Otherwise go to IDLE.
- enable deasserted mid-word: the current word completes fully; no new fetch starts.
- fifo_empty is sampled only in IDLE and at the last-byte edge, so the FIFO is never read while empty.
- Latency (default, byte_ready tied high, edge k = IDLE decision):
  - fifo_rd high in cycle k+1.
  - Capture at the end of cycle k+2.
  - First byte valid in cycle k+3, last byte in cycle k+6.
  - Back-to-back words: 6 cycles per word (REQ + WAIT + 4 SEND).
- The FIFO is never issued more than one outstanding read.

Test Plan:
1. Reset check: rst=0 asynchronously mid-cycle -> all outputs 0 immediately. Release rst with fifo_empty=1, enable=1 -> fifo_rd stays 0 for 20 cycles, busy=0.
2. Single word, MSB_FIRST=1: fifo_data=32'hA1B2C3D4, byte_ready=1 -> exactly one fifo_rd pulse. Bytes A1,B2,C3,D4 on consecutive cycles, byte_last only on D4, word_count=1, return to IDLE.
3. Backpressure: byte_ready=0 for 5 cycles on the second byte -> byte_out=B2 and byte_valid=1 held stable. Sequence resumes with no byte lost or duplicated.
4. Back-to-back: FIFO holds 11223344 and 55667788, enable=1, byte_ready=1 -> bytes 11,22,33,44,55,66,77,88. fifo_rd pulses are 6 cycles apart, word_count=2, then IDLE once empty.
5. Mid-word controls: drop enable after the first byte -> the word finishes, no further fifo_rd. Separately, pulse rst low during the third byte -> immediate return to IDLE with word_count=0.
6. MSB_FIRST=0 and wrap: 32'hA1B2C3D4 -> D4,C3,B2,A1. Preload word_count to 16'hFFFF via repeated words (or force) -> the next completed word wraps it to 0.
